fsgn_unit: RTL and testbench

FSGN_UNIT -- requirements
Module: fsgn_unit

---
 rtl/fpu_pkg.sv | 47 ++++
 rtl/fsgn_core.sv | 57 +++++
 rtl/fsgn_unit.sv | 170 +++++++++++++++++
 tb/tb_fsgn_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and helpers for the sign-injection unit.
//   fsgn_op_e   : operation encoding carried on the op port
//   buf_state_e : occupancy of the two-entry output buffer
//   is_nan()    : NaN detect for any exponent/mantissa split up to the
//                 MAX_* limits. The widths are passed as constant arguments,
//                 so synthesis reduces the loops to an AND/OR tree.
// The NaN helper is used only when FSGN_NAN_CHECK_EN is defined.
package fpu_pkg;

    typedef enum logic [1:0] {
        FSGNJ  = 2'b00,
        FSGNJN = 2'b01,
        FSGNJX = 2'b10,
        FABS   = 2'b11
    } fsgn_op_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_e;

    localparam int MAX_EXP_W = 15;
    localparam int MAX_MAN_W = 112;
    localparam int MAX_W     = 1 + MAX_EXP_W + MAX_MAN_W;

    // Exponent all ones and mantissa nonzero. Infinity has a zero mantissa
    // and is not a NaN.
    function automatic logic is_nan(input logic [MAX_W-1:0] v,
                                    input int exp_w,
                                    input int man_w);
        logic [MAX_W-1:0] exp_bits;
        logic             exp_ones;
        logic             man_nz;
        exp_bits = v >> man_w;
        exp_ones = 1'b1;
        man_nz   = 1'b0;
        for (int i = 0; i < MAX_EXP_W; i++) begin
            if (i < exp_w) exp_ones = exp_ones & exp_bits[i];
        end
        for (int i = 0; i < MAX_MAN_W; i++) begin
            if (i < man_w) man_nz = man_nz | v[i];
        end
        return exp_ones & man_nz;
    endfunction

endpackage

// File: rtl/fsgn_core.sv
// fsgn_core: combinational sign injection (fsgnj/fsgnjn/fsgnjx/fabs).
//   op        : operation, fsgn_op_e encoding
//   x1        : magnitude source operand
//   x2        : sign source operand
//   y         : {injected sign, x1 magnitude}
//   exception : NaN operand flag (constant 0 unless FSGN_NAN_CHECK_EN)
// NaN operands pass through unmodified; the flag only reports them.
module fsgn_core
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [1:0]           op,
    input  logic [EXP_W+MAN_W:0] x1,
    input  logic [EXP_W+MAN_W:0] x2,
    output logic [EXP_W+MAN_W:0] y,
    output logic                 exception
);

    localparam int W = 1 + EXP_W + MAN_W;

    fsgn_op_e op_e;
    logic     sign;

    assign op_e = fsgn_op_e'(op);

    always_comb begin
        sign = 1'b0;
        unique case (op_e)
            FSGNJ:  sign = x2[W-1];
            FSGNJN: sign = ~x2[W-1];
            FSGNJX: sign = x1[W-1] ^ x2[W-1];
            FABS:   sign = 1'b0;
            default: sign = 1'b0;
        endcase
    end

    assign y = {sign, x1[W-2:0]};

`ifdef FSGN_NAN_CHECK_EN
    logic x1_nan;
    logic x2_nan;

    assign x1_nan = is_nan(MAX_W'(x1), EXP_W, MAN_W);
    assign x2_nan = is_nan(MAX_W'(x2), EXP_W, MAN_W);

    // fabs ignores x2 entirely, so a NaN there is not reported.
    assign exception = x1_nan | (x2_nan & (op_e != FABS));
`else
    logic unused_x2_mag;

    assign unused_x2_mag = ^x2[W-2:0];
    assign exception     = 1'b0;
`endif

endmodule

// File: rtl/fsgn_unit.sv
// fsgn_unit: sign-injection unit with a valid/ready handshake on each side.
//   clk, rstn          : clock, asynchronous active-low reset
//   in_valid/in_ready  : operation handshake (op, x1, x2, in_tag)
//   out_valid/out_ready: result handshake (y, exception, out_tag)
//   exc_count          : saturating count of delivered exception results
// Optional macro FSGN_NAN_CHECK_EN enables the NaN flag and exc_count.
// Without it, exception and exc_count are tied to 0.
//
// Buffer states:
//   state     | meaning
//   BUF_EMPTY | no result held, out_valid=0
//   BUF_ONE   | main register valid, skid empty
//   BUF_TWO   | main and skid valid, in_ready=0
//
// in_ready is a flop that depends only on skid occupancy. That keeps it off
// the out_ready path, and the skid register absorbs the one operation that
// can arrive in the same cycle the consumer stalls.
module fsgn_unit
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [EXP_W+MAN_W:0] x1,
    input  logic [EXP_W+MAN_W:0] x2,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] y,
    output logic                 exception,
    output logic [TAG_W-1:0]     out_tag,
    output logic [CNT_W-1:0]     exc_count
);

    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] core_y;
    logic         core_exc;

    fsgn_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_core (
        .op        (op),
        .x1        (x1),
        .x2        (x2),
        .y         (core_y),
        .exception (core_exc)
    );

    buf_state_e       state_q,     state_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     main_y_q,    main_y_d;
    logic             main_exc_q,  main_exc_d;
    logic [TAG_W-1:0] main_tag_q,  main_tag_d;
    logic [W-1:0]     skid_y_q,    skid_y_d;
    logic             skid_exc_q,  skid_exc_d;
    logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;

    logic push;
    logic pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        state_d    = state_q;
        main_y_d   = main_y_q;
        main_exc_d = main_exc_q;
        main_tag_d = main_tag_q;
        skid_y_d   = skid_y_q;
        skid_exc_d = skid_exc_q;
        skid_tag_d = skid_tag_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    main_y_d   = core_y;
                    main_exc_d = core_exc;
                    main_tag_d = in_tag;
                    state_d    = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push && !pop) begin
                    skid_y_d   = core_y;
                    skid_exc_d = core_exc;
                    skid_tag_d = in_tag;
                    state_d    = BUF_TWO;
                end else if (push && pop) begin
                    main_y_d   = core_y;
                    main_exc_d = core_exc;
                    main_tag_d = in_tag;
                end else if (pop) begin
                    state_d    = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    main_y_d   = skid_y_q;
                    main_exc_d = skid_exc_q;
                    main_tag_d = skid_tag_q;
                    state_d    = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        in_ready_d  = (state_d != BUF_TWO);
        out_valid_d = (state_d != BUF_EMPTY);
    end

`ifdef FSGN_NAN_CHECK_EN
    logic [CNT_W-1:0] exc_count_q, exc_count_d;

    always_comb begin
        exc_count_d = exc_count_q;
        if (pop && main_exc_q && (exc_count_q != {CNT_W{1'b1}})) begin
            exc_count_d = exc_count_q + 1'b1;
        end
    end

    assign exc_count = exc_count_q;
`else
    assign exc_count = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= BUF_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_y_q    <= '0;
            main_exc_q  <= 1'b0;
            main_tag_q  <= '0;
            skid_y_q    <= '0;
            skid_exc_q  <= 1'b0;
            skid_tag_q  <= '0;
`ifdef FSGN_NAN_CHECK_EN
            exc_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_y_q    <= main_y_d;
            main_exc_q  <= main_exc_d;
            main_tag_q  <= main_tag_d;
            skid_y_q    <= skid_y_d;
            skid_exc_q  <= skid_exc_d;
            skid_tag_q  <= skid_tag_d;
`ifdef FSGN_NAN_CHECK_EN
            exc_count_q <= exc_count_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = main_y_q;
    assign exception = main_exc_q;
    assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_fsgn_unit.sv
// tb_fsgn_unit: bench for fsgn_unit. It drives a binary32 instance (dut_a)
// and a binary64 instance (dut_b) with shared handshake controls and tags.
// A queue of expected results serves as the reference buffer for both.
module tb_fsgn_unit;

    localparam int TAG_W  = 4;
    localparam int CNT_W  = 16;
    localparam int MAXCNT = (1 << CNT_W) - 1;
`ifdef FSGN_NAN_CHECK_EN
    localparam bit NAN_EN = 1'b1;
`else
    localparam bit NAN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn      = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [1:0]       op        = 2'b00;
    logic [TAG_W-1:0] in_tag    = '0;
    logic [31:0]      a_x1 = '0, a_x2 = '0;
    logic [63:0]      b_x1 = '0, b_x2 = '0;

    logic             a_in_ready, a_out_valid, a_exc;
    logic [31:0]      a_y;
    logic [TAG_W-1:0] a_tag;
    logic [CNT_W-1:0] a_cnt;
    logic             b_in_ready, b_out_valid, b_exc;
    logic [63:0]      b_y;
    logic [TAG_W-1:0] b_tag;
    logic [CNT_W-1:0] b_cnt;

    fsgn_unit #(.EXP_W(8), .MAN_W(23), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(a_in_ready),
        .op(op), .x1(a_x1), .x2(a_x2), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .y(a_y),
        .exception(a_exc), .out_tag(a_tag), .exc_count(a_cnt)
    );

    fsgn_unit #(.EXP_W(11), .MAN_W(52), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(b_in_ready),
        .op(op), .x1(b_x1), .x2(b_x2), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .y(b_y),
        .exception(b_exc), .out_tag(b_tag), .exc_count(b_cnt)
    );

    typedef struct {
        logic [31:0]      y_a;
        logic             exc_a;
        logic [63:0]      y_b;
        logic             exc_b;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;
    int   dut_pops = 0;
    int   dut_pushes = 0;

    bit          force_en  = 1'b0;
    logic [31:0] force_y   = '0;
    logic        force_exc = 1'b0;

    function automatic logic ref_nan(input logic [63:0] v, input int ew, input int mw);
        logic [63:0] e_mask, m_mask;
        e_mask = (64'd1 << ew) - 64'd1;
        m_mask = (64'd1 << mw) - 64'd1;
        return (((v >> mw) & e_mask) == e_mask) && ((v & m_mask) != 64'd0);
    endfunction

    function automatic logic [63:0] ref_y(input logic [1:0] o, input logic [63:0] x1,
                                          input logic [63:0] x2, input int ew, input int mw);
        int   sb;
        logic s;
        sb = ew + mw;
        case (o)
            2'b00:   s = x2[sb];
            2'b01:   s = !x2[sb];
            2'b10:   s = x1[sb] ^ x2[sb];
            default: s = 1'b0;
        endcase
        return (x1 & ~(64'd1 << sb)) | (64'(s) << sb);
    endfunction

    function automatic logic ref_exc(input logic [1:0] o, input logic [63:0] x1,
                                     input logic [63:0] x2, input int ew, input int mw);
        return NAN_EN && (ref_nan(x1, ew, mw) || (o != 2'b11 && ref_nan(x2, ew, mw)));
    endfunction

    // Random operand biased towards NaN, infinity and zero encodings.
    function automatic logic [63:0] rand_fp(input int ew, input int mw);
        logic [63:0] s, e, m, e_mask, m_mask;
        int          k;
        e_mask = (64'd1 << ew) - 64'd1;
        m_mask = (64'd1 << mw) - 64'd1;
        k = int'($urandom_range(0, 4));
        s = 64'($urandom_range(0, 1));
        e = 64'($urandom) & e_mask;
        m = {$urandom, $urandom} & m_mask;
        case (k)
            1: begin e = e_mask; if (m == 64'd0) m = 64'd1; end
            2: begin e = e_mask; m = 64'd0; end
            3: begin e = 64'd0;  m = 64'd0; end
            default: ;
        endcase
        return (s << (ew + mw)) | (e << mw) | m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rand();
        logic [63:0] t;
        op = 2'($urandom_range(0, 3));
        in_tag = TAG_W'($urandom);
        t = rand_fp(8, 23);  a_x1 = t[31:0];
        t = rand_fp(8, 23);  a_x2 = t[31:0];
        b_x1 = rand_fp(11, 52);
        b_x2 = rand_fp(11, 52);
    endtask

    // One clock: check outputs at the falling edge against the reference
    // buffer, advance the reference, then return 1 time unit after the rising edge.
    task automatic cycle();
        exp_t e;
        bit   push, pop;
        @(negedge clk);
        chk("a_out_valid", 64'(a_out_valid), 64'(q.size() > 0));
        chk("b_out_valid", 64'(b_out_valid), 64'(q.size() > 0));
        chk("a_in_ready",  64'(a_in_ready),  64'(q.size() < 2));
        chk("b_in_ready",  64'(b_in_ready),  64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("a_y",   64'(a_y),   64'(q[0].y_a));
            chk("a_exc", 64'(a_exc), 64'(q[0].exc_a));
            chk("a_tag", 64'(a_tag), 64'(q[0].tag));
            chk("b_y",   b_y,        q[0].y_b);
            chk("b_exc", 64'(b_exc), 64'(q[0].exc_b));
            chk("b_tag", 64'(b_tag), 64'(q[0].tag));
        end
        chk("a_exc_count", 64'(a_cnt), 64'(cnt_a));
        chk("b_exc_count", 64'(b_cnt), 64'(cnt_b));
        if (a_out_valid && out_ready) dut_pops++;
        if (a_in_ready && in_valid) dut_pushes++;
        push = in_valid && (q.size() < 2);
        pop  = out_ready && (q.size() > 0);
        if (pop) begin
            e = q.pop_front();
            if (e.exc_a && cnt_a < MAXCNT) cnt_a++;
            if (e.exc_b && cnt_b < MAXCNT) cnt_b++;
        end
        if (push) begin
            e.y_a   = force_en ? force_y : 32'(ref_y(op, 64'(a_x1), 64'(a_x2), 8, 23));
            e.exc_a = force_en ? (NAN_EN && force_exc) : ref_exc(op, 64'(a_x1), 64'(a_x2), 8, 23);
            e.y_b   = ref_y(op, b_x1, b_x2, 11, 52);
            e.exc_b = ref_exc(op, b_x1, b_x2, 11, 52);
            e.tag   = in_tag;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input logic [1:0] o, input logic [31:0] x1, input logic [31:0] x2,
                            input logic [31:0] ey, input logic ee);
        set_rand();
        op = o; a_x1 = x1; a_x2 = x2; in_valid = 1'b1;
        force_en = 1'b1; force_y = ey; force_exc = ee;
        cycle();
        force_en = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_a_out_valid"}, 64'(a_out_valid), 64'd0);
        chk({tag, "_b_out_valid"}, 64'(b_out_valid), 64'd0);
        chk({tag, "_a_in_ready"},  64'(a_in_ready),  64'd1);
        chk({tag, "_b_in_ready"},  64'(b_in_ready),  64'd1);
        chk({tag, "_a_y"},   64'(a_y),   64'd0);
        chk({tag, "_b_y"},   b_y,        64'd0);
        chk({tag, "_a_exc"}, 64'(a_exc), 64'd0);
        chk({tag, "_b_exc"}, 64'(b_exc), 64'd0);
        chk({tag, "_a_tag"}, 64'(a_tag), 64'd0);
        chk({tag, "_b_tag"}, 64'(b_tag), 64'd0);
        chk({tag, "_a_cnt"}, 64'(a_cnt), 64'd0);
        chk({tag, "_b_cnt"}, 64'(b_cnt), 64'd0);
    endtask

    initial begin
        int p0, d0;

        // Reset, then an operation presented on the first edge after release.
        repeat (2) @(posedge clk);
        #1;
        reset_check("rst");
        rstn = 1'b1;
        out_ready = 1'b1;

        // Directed binary32 vectors, back to back.
        directed(2'b10, 32'hBF800000, 32'hC0000000, 32'h3F800000, 1'b0);
        directed(2'b00, 32'hBF800000, 32'hC0000000, 32'hBF800000, 1'b0);
        directed(2'b01, 32'hBF800000, 32'hC0000000, 32'h3F800000, 1'b0);
        directed(2'b11, 32'hC0400000, 32'h12345678, 32'h40400000, 1'b0);
        directed(2'b11, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 1'b1);
        directed(2'b10, 32'h7F800000, 32'hFF800000, 32'hFF800000, 1'b0);
        directed(2'b10, 32'h7F800000, 32'hFF800001, 32'hFF800000, 1'b1);
        directed(2'b11, 32'h00000000, 32'hFFC00000, 32'h00000000, 1'b0);
        in_valid = 1'b0;
        cycle();

        // Consumer stalls for three cycles while operations keep coming.
        out_ready = 1'b0;
        d0 = dut_pushes;
        for (int i = 0; i < 3; i++) begin
            set_rand();
            in_valid = 1'b1;
            cycle();
        end
        chk("stall_accepts", 64'(dut_pushes - d0), 64'd2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // 100 operations streamed with no bubble.
        p0 = dut_pops;
        d0 = dut_pushes;
        for (int i = 0; i < 100; i++) begin
            set_rand();
            in_tag = TAG_W'(i);
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("stream_accepts", 64'(dut_pushes - d0), 64'd100);
        chk("stream_results", 64'(dut_pops - p0), 64'd100);

        // Fill both entries, then reset mid-operation.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_rand();
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        #2;
        rstn = 1'b0;
        #1;
        reset_check("midrst");
        q.delete();
        cnt_a = 0;
        cnt_b = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        cycle();

        // Random traffic with random stalls on both sides.
        for (int i = 0; i < 400; i++) begin
            set_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
